// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM state type.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} alu_state_e;
endpackage

// File: rtl/alu_serial_mul.sv
// Shift-add multiplier, one multiplier bit per cycle, WIDTH iterations.
// done pulses during the last iteration; prod is valid in that same cycle.
module alu_serial_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;

  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + 1'b1;
      busy   <= !done;
    end
  end
endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready handshake.
// Define ALU_MUL_EN to enable the serial multiplier (code 1000) and MUL/HOLD states.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             illegal_o
);
  logic [WIDTH-1:0] op_res, sum, diff;
  logic             op_ovf, op_ill, accept;

  assign sum  = src1_i + src2_i;
  assign diff = src1_i - src2_i;

  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    op_ill = 1'b0;
    case (ALUCtrl_i)
      ALU_AND: op_res = src1_i & src2_i;
      ALU_OR:  op_res = src1_i | src2_i;
      ALU_ADD: begin
        op_res = sum;
        op_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SUB: begin
        op_res = diff;
        op_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      default: op_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_e       state;
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign in_ready_o = (state == ST_IDLE) && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign mul_start  = accept && (ALUCtrl_i == ALU_MUL);

  alu_serial_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk_i), .rst(rst_i), .start(mul_start),
    .a(src1_i), .b(src2_i), .done(mul_done), .prod(mul_prod)
  );
`else
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
`ifdef ALU_MUL_EN
      state <= ST_IDLE;
`endif
      out_valid_o <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b0;
      overflow_o  <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
`ifdef ALU_MUL_EN
      case (state)
        ST_IDLE: begin
          // accept implies any old result is retired on this edge
          if (mul_start) begin
            out_valid_o <= 1'b0;
            state       <= ST_MUL;
          end else if (accept) begin
            out_valid_o <= 1'b1;
            result_o    <= op_res;
            zero_o      <= (op_res == '0);
            overflow_o  <= op_ovf;
            illegal_o   <= op_ill;
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
          end
        end
        ST_MUL: if (mul_done) begin
          out_valid_o <= 1'b1;
          result_o    <= mul_prod;
          zero_o      <= (mul_prod == '0);
          overflow_o  <= 1'b0;
          illegal_o   <= 1'b0;
          state       <= ST_HOLD;
        end
        ST_HOLD: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
`else
      if (accept) begin
        out_valid_o <= 1'b1;
        result_o    <= op_res;
        zero_o      <= (op_res == '0);
        overflow_o  <= op_ovf;
        illegal_o   <= op_ill;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage that sits directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code plus two operands through a valid/ready handshake and returns a registered result with zero/overflow flags. Single-cycle operations (and, or, add, sub, slt) complete with one-cycle latency. An optional iterative multiplier takes WIDTH cycles. The stage replaces the purely combinational ALU wherever the datapath needs back-pressure or multi-cycle operations.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  request valid
- in_ready_o  out  1  stage can accept a request this cycle
- ALUCtrl_i  in  4  operation: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1000 mul (only with ALU_MUL_EN)
- src1_i  in  WIDTH  operand A
- src2_i  in  WIDTH  operand B
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  WIDTH  result
- zero_o  out  1  result_o == 0
- overflow_o  out  1  signed overflow; add/sub only, 0 otherwise
- illegal_o  out  1  the request carried an unsupported code

## Operation
- FSM states: IDLE, MUL, HOLD.
- IDLE:
  - in_ready_o = !out_valid_o || out_ready_i.
  - An accepted single-cycle op loads result and flags, and sets out_valid_o on the next edge. The state stays IDLE.
  - An accepted mul latches the operands, clears out_valid_o if the old result is consumed on the same edge, and moves to MUL.
- MUL:
  - in_ready_o = 0.
  - Shift-add, one multiplier bit per cycle, WIDTH iterations (counter 0..WIDTH-1).
  - At the last iteration: load the low WIDTH bits of the product, set out_valid_o, go to HOLD.
- HOLD: in_ready_o = 0. When out_ready_i = 1, clear out_valid_o and go to IDLE.
- Output register holds result_o and all flags stable while out_valid_o = 1 and out_ready_i = 0.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - overflow_o for add: operands have the same sign and the result sign differs.
  - overflow_o for sub: operands have different signs and the result sign differs from src1_i.
  - slt: signed compare; result 1 or 0, zero-extended.
  - mul: low WIDTH bits; signedness is irrelevant for the low half.
- Illegal code: result_o = 0, zero_o = 1, overflow_o = 0, illegal_o = 1, one-cycle latency. illegal_o = 0 for every legal op.
- Request and consume on the same edge in IDLE: the old result is retired and the new result is loaded (full throughput, one op per cycle).
- Reset, asynchronous, including mid-MUL:
  - state IDLE, counter 0.
  - out_valid_o = 0, result_o = 0, zero_o = 0, overflow_o = 0, illegal_o = 0.
  - in_ready_o = 1 while rst_i is deasserted.
  - Any in-flight multiply is discarded.

## Timing
- Single-cycle op: accepted at edge N, out_valid_o high after edge N.
- mul: accepted at edge N, out_valid_o high after edge N+WIDTH.
- in_ready_o is combinational from state, out_valid_o and out_ready_i. There are no combinational paths from the data inputs to any output.
- in_valid_i may drop without being accepted. Input fields are sampled only on the accepting edge.
- Once out_valid_o rises, it stays high until the result is consumed.

## Configuration
- ALU_MUL_EN defined: code 1000 runs the serial multiplier; the MUL and HOLD states exist.
- ALU_MUL_EN undefined: code 1000 is illegal (illegal_o = 1). The FSM reduces to IDLE only, with no counter or multiplier registers.

## Structure
- Shared package alu_pkg:
  - localparams for the five (six) ALUCtrl codes, so the decoder and this stage share them.
  - The FSM state typedef.
- Sub-module alu_serial_mul contains the counter, accumulator, multiplicand/multiplier shift registers and the done pulse. It is instantiated only under ALU_MUL_EN.

## Test plan
- Reset released; add 5 + 7 with out_ready_i = 1 → result_o = 12 one cycle later, zero_o = 0, overflow_o = 0.
- sub 0x7FFFFFFF − 0xFFFFFFFF → result_o = 0x80000000, overflow_o = 1. slt −1 vs 1 → result_o = 1.
- Back-pressure:
  - add 1+1 issued with out_ready_i = 0 → result 2 held and in_ready_o = 0 for 3 cycles.
  - out_ready_i then raised together with a new request (and 0xF0 & 0x3C) → result 0x30 on the next cycle, no bubble.
- ALU_MUL_EN defined: mul 0x0001_0003 × 7 → result_o = 0x0007_0015 exactly 32 cycles after acceptance, in_ready_o = 0 throughout.
- Same mul with rst_i pulsed at cycle 10 → out_valid_o = 0 and in_ready_o = 1 after reset; the next add 2+2 returns 4 normally.
- Code 0101, and code 1000 with ALU_MUL_EN undefined → illegal_o = 1, result_o = 0, zero_o = 1, one-cycle latency.
